bus2_line_master: RTL and testbench

- Cache-side initiator for bus 2 (A2/D2/C2). It is the requester end of the memory-controller line protocol.
- Accepts one line read or line write at a time from cache control logic.
- Issues C2_READ_LINE / C2_WRITE_LINE on the shared bus and streams the line as 16-bit little-endian beats.
- Waits for C2_RESPONSE from the memory controller, then returns the line, or a write acknowledge, to the client.

---
 rtl/bus2_line_master.sv | 194 +++++++++++++++++++
 tb/tb_bus2_line_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus2_line_master.sv
// bus2_line_master: cache-side requester for the bus-2 line protocol (A2/D2/C2).
// Build macro BUS2_TIMEOUT_EN adds a response-wait timeout that ends the transaction with rsp_err.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | req_ready high, waiting for a client request
// S_ISSUE     | drive A2 + command on C2 (and beat 0 on D2 for a write)
// S_WR_DATA   | stream write beats 1..BEATS-1 on D2
// S_WAIT_RESP | bus released, watching C2 for RESPONSE
// S_RD_DATA   | capture read beats 1..BEATS-1 from D2
// S_DONE      | rsp_valid pulse, then back to S_IDLE
module bus2_line_master #(
   parameter int ADDR2_BUS_SIZE  = 15,
   parameter int DATA_BUS_SIZE   = 16,
   parameter int CTR2_BUS_SIZE   = 2,
   parameter int CACHE_LINE_SIZE = 16,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                           CLK,
   input  logic                           RESET,
   inout  wire  [ADDR2_BUS_SIZE-1:0]      A2_WIRE,
   inout  wire  [DATA_BUS_SIZE-1:0]       D2_WIRE,
   inout  wire  [CTR2_BUS_SIZE-1:0]       C2_WIRE,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [ADDR2_BUS_SIZE-1:0]      req_addr,
   input  logic [CACHE_LINE_SIZE*8-1:0]   req_wdata,
   output logic                           rsp_valid,
   output logic [CACHE_LINE_SIZE*8-1:0]   rsp_rdata,
   output logic                           rsp_err
);

   localparam int BEATS  = CACHE_LINE_SIZE / 2;
   localparam int LINE_W = CACHE_LINE_SIZE * 8;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
   localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
   localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WR_DATA, S_WAIT_RESP, S_RD_DATA, S_DONE
   } state_t;

   state_t                       state_q;
   logic                         req_ready_q, rsp_valid_q, err_q, write_q;
   logic [BEAT_W-1:0]            beat_q, beat_inc;
   logic [LINE_W-1:0]            wdata_q, rd_buf_q, rd_merge, rsp_rdata_q;
   logic [DATA_BUS_SIZE-1:0]     wr_next;
   logic                         a2_oe_q, c2_oe_q, d2_oe_q;
   logic [ADDR2_BUS_SIZE-1:0]    a2_q;
   logic [CTR2_BUS_SIZE-1:0]     c2_q;
   logic [DATA_BUS_SIZE-1:0]     d2_q;
   logic                         resp_seen, tmo_done;

   assign A2_WIRE = a2_oe_q ? a2_q : 'z;
   assign C2_WIRE = c2_oe_q ? c2_q : 'z;
   assign D2_WIRE = d2_oe_q ? d2_q : 'z;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = err_q;

   // X/Z on C2 compares false, so it never counts as RESPONSE.
   assign resp_seen = (C2_WIRE == C2_RESPONSE);
   assign beat_inc  = beat_q + BEAT_W'(1);
   assign wr_next   = wdata_q[int'(beat_inc)*DATA_BUS_SIZE +: DATA_BUS_SIZE];

   always_comb begin
      rd_merge = rd_buf_q;
      rd_merge[int'(beat_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_WIRE;
   end

`ifdef BUS2_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q;

   // Reloaded outside WAIT_RESP; terminal count reached after TIMEOUT_CYCLES samples.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         tmo_q <= TMO_LOAD;
      else if (state_q != S_WAIT_RESP)
         tmo_q <= TMO_LOAD;
      else if (tmo_q != '0)
         tmo_q <= tmo_q - TMO_W'(1);
   end
   assign tmo_done = (tmo_q == '0);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign tmo_done = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         write_q     <= 1'b0;
         beat_q      <= '0;
         wdata_q     <= '0;
         rd_buf_q    <= '0;
         rsp_rdata_q <= '0;
         a2_oe_q     <= 1'b0;
         c2_oe_q     <= 1'b0;
         d2_oe_q     <= 1'b0;
         a2_q        <= '0;
         c2_q        <= '0;
         d2_q        <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: if (req_valid) begin
               state_q     <= S_ISSUE;
               req_ready_q <= 1'b0;
               write_q     <= req_write;
               wdata_q     <= req_wdata;
               beat_q      <= '0;
               a2_q        <= req_addr;
               a2_oe_q     <= 1'b1;
               c2_q        <= req_write ? C2_WRITE_LINE : C2_READ_LINE;
               c2_oe_q     <= 1'b1;
               d2_q        <= req_wdata[DATA_BUS_SIZE-1:0];
               d2_oe_q     <= req_write;
            end
            S_ISSUE: begin
               a2_oe_q <= 1'b0;
               c2_oe_q <= 1'b0;
               if (write_q && BEATS > 1) begin
                  state_q <= S_WR_DATA;
                  beat_q  <= beat_inc;
                  d2_q    <= wr_next;
               end else begin
                  state_q <= S_WAIT_RESP;
                  d2_oe_q <= 1'b0;
               end
            end
            S_WR_DATA: begin
               if (beat_q == LAST_BEAT) begin
                  state_q <= S_WAIT_RESP;
                  d2_oe_q <= 1'b0;
                  beat_q  <= '0;
               end else begin
                  beat_q <= beat_inc;
                  d2_q   <= wr_next;
               end
            end
            S_WAIT_RESP: begin
               if (resp_seen) begin
                  err_q <= 1'b0;
                  if (write_q) begin
                     state_q     <= S_DONE;
                     rsp_valid_q <= 1'b1;
                  end else if (BEATS == 1) begin
                     state_q     <= S_DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rd_merge;
                  end else begin
                     state_q  <= S_RD_DATA;
                     rd_buf_q <= rd_merge;
                     beat_q   <= beat_inc;
                  end
               end else if (tmo_done) begin
                  state_q     <= S_DONE;
                  rsp_valid_q <= 1'b1;
                  err_q       <= 1'b1;
               end
            end
            S_RD_DATA: begin
               rd_buf_q <= rd_merge;
               if (beat_q == LAST_BEAT) begin
                  state_q     <= S_DONE;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rd_merge;
               end else begin
                  beat_q <= beat_inc;
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               beat_q      <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus2_line_master.sv
// Bench for bus2_line_master: vector table, random transactions against a line-level model,
// and hand sequences for reset mid-transaction, back-to-back requests and a silent responder.
module tb_bus2_line_master;
`ifdef BUS2_TIMEOUT_EN
   localparam int TMO = 10;
`else
   localparam int TMO = 255;
`endif

   logic          CLK = 1'b0;
   logic          RESET;
   wire  [14:0]   A2_WIRE;
   wire  [15:0]   D2_WIRE;
   wire  [1:0]    C2_WIRE;
   logic          req_valid, req_ready, req_write, rsp_valid, rsp_err;
   logic [14:0]   req_addr;
   logic [127:0]  req_wdata, rsp_rdata;

   logic          tb_c2_en, tb_d2_en;
   logic [1:0]    tb_c2;
   logic [15:0]   tb_d2;
   assign C2_WIRE = tb_c2_en ? tb_c2 : 'z;
   assign D2_WIRE = tb_d2_en ? tb_d2 : 'z;

   int            total = 0;
   int            bad = 0;
   logic [127:0]  last_rd;

   typedef struct {
      bit            wr;
      logic [14:0]   addr;
      logic [127:0]  line;
      int            delay;
      logic [127:0]  exp_rdata;
   } vec_t;
   vec_t vecs[5];

   bus2_line_master #(
      .ADDR2_BUS_SIZE(15), .DATA_BUS_SIZE(16), .CTR2_BUS_SIZE(2),
      .CACHE_LINE_SIZE(16), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .A2_WIRE(A2_WIRE), .D2_WIRE(D2_WIRE), .C2_WIRE(C2_WIRE),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // A released bus reads as Z in 4-state simulators and as 0 in 2-state ones.
   task automatic chk_rel(input string nm, input logic [127:0] act);
      total++;
      if (!($isunknown(act) || act == '0)) begin
         bad++;
         $display("FAIL %s: got %h want released", nm, act);
      end
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Starts and ends at a negedge with the block idle.
   task automatic do_txn(input bit wr, input logic [14:0] addr, input logic [127:0] line,
                         input int delay, input bit hold, input logic [127:0] exp_rdata);
      int ch;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = line;
      chk("idle_ready", req_ready, 1);
      cyc();
      if (!hold) req_valid = 1'b0;
      chk("issue_ready", req_ready, 0);
      chk("issue_a2", A2_WIRE, addr);
      chk("issue_c2", C2_WIRE, wr ? 2'd3 : 2'd2);
      if (wr) chk("issue_d2", D2_WIRE, line[15:0]);
      else    chk_rel("issue_d2", D2_WIRE);
      if (wr) begin
         for (int k = 1; k < 8; k++) begin
            cyc();
            chk("wr_beat", D2_WIRE, line[16*k +: 16]);
            chk_rel("wr_a2", A2_WIRE);
            chk_rel("wr_c2", C2_WIRE);
         end
      end
      for (int i = 0; i <= delay; i++) begin
         cyc();
         chk_rel("wait_a2", A2_WIRE);
         chk_rel("wait_d2", D2_WIRE);
         if (!tb_c2_en) chk_rel("wait_c2", C2_WIRE);
         chk("wait_valid", rsp_valid, 0);
         if (i < delay) begin
            ch = $urandom_range(0, 3);
            tb_c2_en = (ch != 0);
            tb_c2 = (ch == 1) ? 2'd0 : 2'(ch);
         end
      end
      tb_c2_en = 1'b1; tb_c2 = 2'd1;
      if (!wr) begin
         tb_d2_en = 1'b1; tb_d2 = line[15:0];
         for (int k = 1; k < 8; k++) begin
            cyc();
            chk("rd_valid", rsp_valid, 0);
            tb_c2 = 2'($urandom());
            tb_d2 = line[16*k +: 16];
         end
      end
      cyc();
      tb_c2_en = 1'b0; tb_d2_en = 1'b0;
      chk("done_valid", rsp_valid, 1);
      chk("done_err", rsp_err, 0);
      chk("done_rdata", rsp_rdata, exp_rdata);
      chk("done_ready", req_ready, 0);
      chk_rel("done_a2", A2_WIRE);
      cyc();
      chk("post_valid", rsp_valid, 0);
      chk("post_ready", req_ready, 1);
   endtask

   initial begin
      logic [127:0] l1, l2, l3, l4, l5, ln;
      bit           wr;
      RESET = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      tb_c2_en = 1'b1; tb_c2 = 2'd0; tb_d2_en = 1'b0; tb_d2 = '0;
      last_rd = '0;

      vecs[0] = '{1'b0, 15'h0123, 128'h100F0E0D0C0B0A090807060504030201, 100,
                  128'h100F0E0D0C0B0A090807060504030201};
      vecs[1] = '{1'b1, 15'h7FFF, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 3,
                  128'h100F0E0D0C0B0A090807060504030201};
      vecs[2] = '{1'b0, 15'h0001, 128'hFFEEDDCCBBAA99887766554433221100, 0,
                  128'hFFEEDDCCBBAA99887766554433221100};
      vecs[3] = '{1'b1, 15'h4000, 128'h0123456789ABCDEF0011223344556677, 0,
                  128'hFFEEDDCCBBAA99887766554433221100};
      vecs[4] = '{1'b0, 15'h2AAA, 128'h0, 1, 128'h0};

      #12;
      chk_rel("rst_a2", A2_WIRE);
      chk_rel("rst_d2", D2_WIRE);
      chk("rst_c2_nop", C2_WIRE, 2'd0);
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      @(negedge CLK);
      RESET = 1'b1; tb_c2_en = 1'b0;
      cyc();

      for (int v = 0; v < 5; v++) begin
         do_txn(vecs[v].wr, vecs[v].addr, vecs[v].line, vecs[v].delay, 1'b0, vecs[v].exp_rdata);
         if (!vecs[v].wr) last_rd = vecs[v].line;
      end

      // read with req_valid held high, write presented right behind it
      l1 = rnd_line(); l2 = rnd_line();
      do_txn(1'b0, 15'h1111, l1, 2, 1'b1, l1);
      last_rd = l1;
      do_txn(1'b1, 15'h2222, l2, 0, 1'b0, last_rd);

      repeat (25) begin
         wr = 1'($urandom());
         ln = rnd_line();
         do_txn(wr, 15'($urandom()) | 15'h1, ln, $urandom_range(0, 6), 1'b0, wr ? last_rd : ln);
         if (!wr) last_rd = ln;
      end

      // reset while the block is streaming write beat 3
      l3 = rnd_line();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h3C3C; req_wdata = l3;
      cyc();
      req_valid = 1'b0;
      cyc(); cyc(); cyc();
      chk("rstw_beat3", D2_WIRE, l3[63:48]);
      RESET = 1'b0;
      #1;
      chk_rel("rstw_d2", D2_WIRE);
      chk_rel("rstw_a2", A2_WIRE);
      chk_rel("rstw_c2", C2_WIRE);
      chk("rstw_ready", req_ready, 1);
      chk("rstw_rdata", rsp_rdata, 0);
      last_rd = '0;
      @(negedge CLK);
      RESET = 1'b1;
      repeat (4) begin
         cyc();
         chk("rstw_novalid", rsp_valid, 0);
         chk_rel("rstw_d2_after", D2_WIRE);
      end

      // reset during read beat 3, then a clean read
      l4 = rnd_line(); l5 = rnd_line();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0456;
      cyc();
      req_valid = 1'b0;
      cyc();
      tb_c2_en = 1'b1; tb_c2 = 2'd1; tb_d2_en = 1'b1; tb_d2 = l4[15:0];
      for (int k = 1; k < 4; k++) begin
         cyc();
         tb_c2 = 2'd0; tb_d2 = l4[16*k +: 16];
      end
      RESET = 1'b0; tb_c2_en = 1'b0; tb_d2_en = 1'b0;
      #1;
      chk_rel("rstr_a2", A2_WIRE);
      chk_rel("rstr_d2", D2_WIRE);
      chk_rel("rstr_c2", C2_WIRE);
      chk("rstr_valid", rsp_valid, 0);
      chk("rstr_ready", req_ready, 1);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (3) begin
         cyc();
         chk("rstr_novalid", rsp_valid, 0);
      end
      do_txn(1'b0, 15'h0457, l5, 4, 1'b0, l5);
      last_rd = l5;

      // silent responder
      req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0ABC;
      cyc();
      req_valid = 1'b0;
      chk("tmo_issue_a2", A2_WIRE, 15'h0ABC);
`ifdef BUS2_TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
         cyc();
         chk("tmo_wait_valid", rsp_valid, 0);
      end
      cyc();
      chk("tmo_valid", rsp_valid, 1);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_rdata", rsp_rdata, last_rd);
      cyc();
      chk("tmo_ready", req_ready, 1);
      // response arriving on the expiry cycle wins
      ln = rnd_line();
      do_txn(1'b0, 15'h0ABD, ln, TMO - 1, 1'b0, ln);
`else
      repeat (1000) begin
         cyc();
         chk("noresp_valid", rsp_valid, 0);
      end
      chk("noresp_ready", req_ready, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
